fifo_flex: RTL



---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_flex_if.sv | 36 +++
 rtl/fifo_ram.sv | 39 +++
 rtl/fifo_flex.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_flex FIFO family.
// Read-mode encodings, count-width helper and threshold-margin legality check.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // One extra bit so a completely full FIFO is distinguishable from empty.
    function automatic int fifo_count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit fifo_margins_legal(input int depth, input int af_margin,
                                              input int ae_margin);
        return (af_margin >= 0) && (af_margin < depth) &&
               (ae_margin >= 0) && (ae_margin < depth);
    endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// Producer/consumer bundle of fifo_flex: master = user side, slave = FIFO side.
// Handshake: a push is taken on a clock edge when push=1 and the FIFO is not full (or pops in the same edge); a pop is taken when pop=1 and empty=0.
interface fifo_flex_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4
);

    logic                                      clear;
    logic                                      push;
    logic                                      pop;
    logic [DATA_WIDTH-1:0]                     data_in;
    logic [DATA_WIDTH-1:0]                     data_out;
    logic                                      valid;
    logic                                      empty;
    logic                                      full;
    logic                                      almost_full;
    logic                                      almost_empty;
    logic [fifo_count_width(ADDR_WIDTH)-1:0]   count;
    logic                                      overflow;
    logic                                      underflow;

    modport master (
        output clear, push, pop, data_in,
        input  data_out, valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, push, pop, data_in,
        output data_out, valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, read-before-write.
// Only the read register is reset; the array itself is not.
module fifo_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Same-address read and write in one edge returns the old word.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO with standard or first-word-fall-through read, exact count and thresholds.
// Sticky overflow/underflow flags exist only when FIFO_ERR_FLAGS_EN is defined.
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_MARGIN  = 3,
    parameter int AE_MARGIN  = 1
) (
    input logic        clk,
    input logic        reset,
    fifo_flex_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = fifo_count_width(ADDR_WIDTH);

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] C_AE    = CW'(AE_MARGIN);
    localparam logic          AF_RST  = (AF_MARGIN >= DEPTH);

    if (!fifo_margins_legal(DEPTH, AF_MARGIN, AE_MARGIN)) begin : g_bad_margins
        $error("fifo_flex: AF_MARGIN/AE_MARGIN must lie in 0..DEPTH-1");
    end

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_af;
    logic                  r_ae;
    logic                  r_valid;
    logic                  r_byp_sel;
    logic [DATA_WIDTH-1:0] r_byp_data;

    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [CW-1:0]         w_count_next;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
    logic                  w_load;
    logic                  w_bypass;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_valid_next;
    logic [DATA_WIDTH-1:0] w_ram_q;

    assign w_pop_ok      = !bus.clear && bus.pop && !r_empty;
    assign w_push_ok     = !bus.clear && bus.push && (!r_full || w_pop_ok);
    assign w_count_next  = bus.clear ? '0 : (r_count + CW'(w_push_ok) - CW'(w_pop_ok));
    assign w_rd_ptr_next = r_rd_ptr + ADDR_WIDTH'(w_pop_ok);

    // FWFT keeps the head word in the output; it reloads when the head is consumed
    // or when the first word arrives. A word written this same edge comes via bypass.
    always_comb begin
        w_load       = 1'b0;
        w_bypass     = 1'b0;
        w_rd_addr    = r_rd_ptr;
        w_valid_next = 1'b0;
        if (FWFT == FIFO_MODE_FWFT) begin
            w_load       = !bus.clear && (w_pop_ok || r_empty) && (w_count_next != '0);
            w_bypass     = w_load && w_push_ok && (r_wr_ptr == w_rd_ptr_next);
            w_rd_addr    = w_rd_ptr_next;
            w_valid_next = (w_count_next != '0);
        end else begin
            w_load       = w_pop_ok;
            w_valid_next = w_pop_ok;
        end
    end

    assign w_rd_en = w_load && !w_bypass;

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_reset   (reset),
        .i_wr_en   (w_push_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.data_in),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_af       <= AF_RST;
            r_ae       <= 1'b1;
            r_valid    <= 1'b0;
            r_byp_sel  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            if (bus.clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                r_rd_ptr <= w_rd_ptr_next;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == C_DEPTH);
            r_af    <= (w_count_next >= C_AF);
            r_ae    <= (w_count_next <= C_AE);
            r_valid <= w_valid_next;
            if (w_load) begin
                r_byp_sel <= w_bypass;
                if (w_bypass) begin
                    r_byp_data <= bus.data_in;
                end
            end
        end
    end

    assign bus.data_out     = r_byp_sel ? r_byp_data : w_ram_q;
    assign bus.valid        = r_valid;
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.almost_full  = r_af;
    assign bus.almost_empty = r_ae;
    assign bus.count        = r_count;

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (!bus.clear && bus.push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (!bus.clear && bus.pop && !w_pop_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule
